// File: rtl/channel_initiator.sv
// Channel initiator: runs one select / command / status / data / ending sequence on the tag bus.
// Optional STOP_EN macro lets the host end a data transfer early with a command_out (stop) reply.
module channel_initiator #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        reset,
   // host side
   input  logic        start,
   input  logic [7:0]  address,
   input  logic [7:0]  command,
   output logic        busy,
   output logic        done,
   output logic [1:0]  result,
   output logic [7:0]  status,
   output logic [15:0] count,
   input  logic [7:0]  tx_data,
   input  logic        tx_valid,
   output logic        tx_ready,
   output logic [7:0]  rx_data,
   output logic        rx_valid,
   input  logic        stop,
   // channel tags
   output logic [7:0]  bus_out,
   output logic        operational_out,
   output logic        select_out,
   output logic        hold_out,
   output logic        address_out,
   output logic        command_out,
   output logic        service_out,
   output logic        suppress_out,
   input  logic [7:0]  bus_in,
   input  logic        operational_in,
   input  logic        select_in,
   input  logic        address_in,
   input  logic        status_in,
   input  logic        service_in,
   input  logic        request_in,
   // debug
   output logic [3:0]  state_dbg
);

   // Streams: tx byte moves when tx_valid && tx_ready in the same cycle; rx_valid is a one-cycle strobe per byte.
   localparam logic [3:0] S_IDLE       = 4'd0;
   localparam logic [3:0] S_SELECT     = 4'd1;
   localparam logic [3:0] S_ADDR_IN    = 4'd2;
   localparam logic [3:0] S_CMD        = 4'd3;
   localparam logic [3:0] S_STAT       = 4'd4;
   localparam logic [3:0] S_STAT_ACK   = 4'd5;
   localparam logic [3:0] S_DATA       = 4'd6;
   localparam logic [3:0] S_DATA_TX    = 4'd7;
   localparam logic [3:0] S_DATA_ACK   = 4'd8;
   localparam logic [3:0] S_STOP_ACK   = 4'd9;
   localparam logic [3:0] S_ENDING     = 4'd10;
   localparam logic [3:0] S_ENDING_ACK = 4'd11;
   localparam logic [3:0] S_END        = 4'd12;

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic [3:0]    state;
   logic [7:0]    addr_q;
   logic [7:0]    cmd_q;
   logic [7:0]    tx_byte_q;
   logic [TW-1:0] timer;
   logic          op_q;
   logic          is_write;
   logic          is_read;
   logic          stop_req;
   logic [15:0]   count_inc;

   assign is_write  = (cmd_q == 8'h01);
   assign is_read   = (cmd_q == 8'h02);
   assign count_inc = (count == 16'hFFFF) ? count : count + 16'd1;

`ifdef STOP_EN
   assign stop_req = stop;
   logic unused_inputs;
   assign unused_inputs = request_in;
`else
   assign stop_req = 1'b0;
   logic unused_inputs;
   assign unused_inputs = request_in ^ stop;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         addr_q    <= 8'h00;
         cmd_q     <= 8'h00;
         tx_byte_q <= 8'h00;
         timer     <= '0;
         op_q      <= 1'b0;
         status    <= 8'h00;
         count     <= 16'h0000;
         result    <= 2'd0;
         rx_data   <= 8'h00;
         rx_valid  <= 1'b0;
      end else begin
         op_q     <= 1'b1;
         rx_valid <= 1'b0;
         case (state)
            S_IDLE: if (start) begin
               addr_q <= address;
               cmd_q  <= command;
               count  <= 16'h0000;
               result <= 2'd0;
               timer  <= '0;
               state  <= S_SELECT;
            end
            S_SELECT: begin
               if (operational_in) state <= S_ADDR_IN;
               else if (select_in || timer == TIMEOUT_LAST) begin
                  result <= 2'd2;
                  state  <= S_END;
               end else timer <= timer + 1'b1;
            end
            S_ADDR_IN: if (address_in) begin
               if (bus_in != addr_q) begin
                  result <= 2'd3;
                  state  <= S_END;
               end else state <= S_CMD;
            end
            S_CMD: if (!address_in) state <= S_STAT;
            S_STAT: if (status_in) begin
               status <= bus_in;
               state  <= S_STAT_ACK;
            end
            // Decision on the initial status is taken once the CU drops status_in.
            S_STAT_ACK: if (!status_in) begin
               if (status[3]) begin
                  result <= 2'd1;
                  state  <= S_END;
               end else if (status[5:4] == 2'b11 || !(is_write || is_read)) begin
                  result <= 2'd0;
                  state  <= S_END;
               end else begin
                  count <= 16'h0000;
                  state <= S_DATA;
               end
            end
            S_DATA: begin
               if (status_in) state <= S_ENDING;
               else if (service_in) begin
                  if (stop_req) state <= S_STOP_ACK;
                  else if (is_write) state <= S_DATA_TX;
                  else begin
                     rx_data  <= bus_in;
                     rx_valid <= 1'b1;
                     count    <= count_inc;
                     state    <= S_DATA_ACK;
                  end
               end
            end
            S_DATA_TX: if (tx_valid) begin
               tx_byte_q <= tx_data;
               count     <= count_inc;
               state     <= S_DATA_ACK;
            end
            S_DATA_ACK: if (!service_in) state <= S_DATA;
            S_STOP_ACK: if (!service_in) state <= S_ENDING;
            S_ENDING: if (status_in) begin
               status <= bus_in;
               state  <= S_ENDING_ACK;
            end
            S_ENDING_ACK: if (!status_in) begin
               result <= 2'd0;
               state  <= S_END;
            end
            S_END:   state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Tags are decoded from state so reset takes them low immediately.
   assign busy            = (state != S_IDLE);
   assign done            = (state == S_END);
   assign select_out      = (state != S_IDLE) && (state != S_END);
   assign hold_out        = select_out;
   assign address_out     = (state == S_SELECT);
   assign command_out     = (state == S_CMD) || (state == S_STOP_ACK);
   assign service_out     = (state == S_STAT_ACK) || (state == S_DATA_ACK) || (state == S_ENDING_ACK);
   assign tx_ready        = (state == S_DATA_TX);
   assign operational_out = op_q;
   assign suppress_out    = 1'b0;
   assign state_dbg       = state;

   always_comb begin
      bus_out = 8'h00;
      case (state)
         S_SELECT:   bus_out = addr_q;
         S_CMD:      bus_out = cmd_q;
         S_DATA_ACK: bus_out = is_write ? tx_byte_q : 8'h00;
         default:    bus_out = 8'h00;
      endcase
   end

endmodule

// File: tb/tb_channel_initiator.sv
// Bench for channel_initiator: a directed vector table, randomized operations against a
// behavioural model of the channel rules, and hand sequences for reset and stop.
module tb_channel_initiator;

   localparam int TIMEOUT     = 16;
   localparam int WAIT_BUDGET = 60;

   localparam int K_NORMAL   = 0;
   localparam int K_NORESP   = 1;
   localparam int K_REJECT   = 2;
   localparam int K_MISMATCH = 3;

   localparam int SIG_SERVICE = 0;
   localparam int SIG_DONE    = 1;
   localparam int SIG_TXREADY = 2;
   localparam int SIG_CMD     = 3;

   typedef struct {
      logic [7:0]  addr;
      logic [7:0]  cmd;
      int          kind;
      logic [7:0]  st0;
      logic [7:0]  st1;
      int          nbytes;
      int          txd;
      bit          use_stop;
      logic [1:0]  exp_res;
      logic [7:0]  exp_st;
      logic [15:0] exp_cnt;
   } vec_t;

   logic        clk, reset;
   logic        start, stop, tx_valid;
   logic [7:0]  address, command, tx_data, bus_in;
   logic        operational_in, select_in, address_in, status_in, service_in, request_in;
   logic        busy, done, tx_ready, rx_valid;
   logic [1:0]  result;
   logic [7:0]  status, rx_data, bus_out;
   logic [15:0] count;
   logic        operational_out, select_out, hold_out, address_out, command_out, service_out, suppress_out;
   logic [3:0]  state_dbg;

   int n_tests = 0;
   int n_fail  = 0;
   logic [7:0] exp_q[$];

   channel_initiator #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
      .clk(clk), .reset(reset),
      .start(start), .address(address), .command(command),
      .busy(busy), .done(done), .result(result), .status(status), .count(count),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .stop(stop),
      .bus_out(bus_out), .operational_out(operational_out), .select_out(select_out),
      .hold_out(hold_out), .address_out(address_out), .command_out(command_out),
      .service_out(service_out), .suppress_out(suppress_out),
      .bus_in(bus_in), .operational_in(operational_in), .select_in(select_in),
      .address_in(address_in), .status_in(status_in), .service_in(service_in),
      .request_in(request_in), .state_dbg(state_dbg)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic clear_inputs();
      start = 1'b0; stop = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
      address = 8'h00; command = 8'h00; bus_in = 8'h00;
      operational_in = 1'b0; select_in = 1'b0; address_in = 1'b0;
      status_in = 1'b0; service_in = 1'b0; request_in = 1'b0;
   endtask

   task automatic apply_reset();
      clear_inputs();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic sig_val(input int sel);
      case (sel)
         SIG_SERVICE: return service_out;
         SIG_DONE:    return done;
         SIG_TXREADY: return tx_ready;
         SIG_CMD:     return command_out;
         default:     return 1'b0;
      endcase
   endfunction

   task automatic wait_sig(input int sel, input logic lvl, input string name);
      int k;
      k = 0;
      while (sig_val(sel) !== lvl && k < WAIT_BUDGET) begin
         @(negedge clk);
         k++;
      end
      n_tests++;
      if (sig_val(sel) !== lvl) begin
         n_fail++;
         $display("FAIL wait_%s: still %0b after %0d cycles, expected %0b", name, sig_val(sel), k, lvl);
      end
   endtask

   // Channel rule: data phase follows an initial status without busy, without CE+DE, for read/write.
   function automatic bit data_phase(input vec_t v);
      return (v.kind == K_NORMAL) && !v.st0[3] && (v.st0[5:4] != 2'b11) &&
             (v.cmd == 8'h01 || v.cmd == 8'h02);
   endfunction

   function automatic void ref_model(input vec_t v, input logic [7:0] prev_st,
                                     output logic [1:0] r, output logic [7:0] s, output logic [15:0] c);
      s = prev_st;
      c = 16'd0;
      if (v.kind == K_NORESP || v.kind == K_REJECT) r = 2'd2;
      else if (v.kind == K_MISMATCH) r = 2'd3;
      else begin
         s = v.st0;
         if (v.st0[3]) r = 2'd1;
         else begin
            r = 2'd0;
            if (data_phase(v)) begin
               s = v.st1;
               c = (v.nbytes > 65535) ? 16'hFFFF : 16'(v.nbytes);
            end
         end
      end
   endfunction

   function automatic vec_t mk(input logic [7:0] addr, input logic [7:0] cmd, input int kind,
                               input logic [7:0] st0, input logic [7:0] st1, input int nbytes,
                               input int txd, input bit use_stop, input logic [1:0] er,
                               input logic [7:0] es, input logic [15:0] ec);
      vec_t v;
      v.addr = addr; v.cmd = cmd; v.kind = kind; v.st0 = st0; v.st1 = st1;
      v.nbytes = nbytes; v.txd = txd; v.use_stop = use_stop;
      v.exp_res = er; v.exp_st = es; v.exp_cnt = ec;
      return v;
   endfunction

   task automatic status_handshake(input logic [7:0] st);
      bus_in = st;
      status_in = 1'b1;
      wait_sig(SIG_SERVICE, 1'b1, "status_service");
      check("status_latch", 32'(status), 32'(st));
      status_in = 1'b0;
      bus_in = 8'h00;
   endtask

   // Driver: host start plus a control-unit model answering the tags.
   task automatic run_op(input vec_t v, input bit rnd,
                         output logic [1:0] r, output logic [7:0] s, output logic [15:0] c);
      int lat;
      bit quiet;
      logic [7:0] b, eb;
      @(negedge clk);
      address = v.addr; command = v.cmd; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("select_tags", 32'({address_out, select_out, hold_out, busy, bus_out}), 32'({4'b1111, v.addr}));
      if (v.kind == K_NORESP) begin
         lat = 0;
         while (!done && lat < TIMEOUT + 8) begin
            @(negedge clk);
            lat++;
         end
         check("timeout_latency", 32'(lat), 32'(TIMEOUT));
      end else if (v.kind == K_REJECT) begin
         select_in = 1'b1;
         @(negedge clk);
         select_in = 1'b0;
      end else begin
         operational_in = 1'b1;
         @(negedge clk);
         check("addr_out_drop", 32'({address_out, select_out}), 32'(2'b01));
         address_in = 1'b1;
         bus_in = (v.kind == K_MISMATCH) ? (v.addr ^ 8'h5A) : v.addr;
         @(negedge clk);
         if (v.kind == K_MISMATCH) begin
            address_in = 1'b0;
            bus_in = 8'h00;
         end else begin
            check("cmd_tags", 32'({command_out, bus_out}), 32'({1'b1, v.cmd}));
            address_in = 1'b0;
            bus_in = 8'h00;
            @(negedge clk);
            check("cmd_out_drop", 32'(command_out), 32'(0));
            status_handshake(v.st0);
            if (data_phase(v)) begin
               for (int k = 0; k < v.nbytes; k++) begin
                  wait_sig(SIG_SERVICE, 1'b0, "service_low");
                  if (v.cmd == 8'h01) begin
                     b = rnd ? 8'($urandom_range(0, 255)) : 8'(8'hAA + 17 * k);
                     service_in = 1'b1;
                     wait_sig(SIG_TXREADY, 1'b1, "tx_ready");
                     quiet = 1'b1;
                     repeat (v.txd) begin
                        @(negedge clk);
                        if (service_out || !tx_ready) quiet = 1'b0;
                     end
                     if (v.txd > 0) check("tx_wait_quiet", 32'(quiet), 32'(1));
                     tx_data = b;
                     tx_valid = 1'b1;
                     @(negedge clk);
                     tx_valid = 1'b0;
                     check("tx_byte", 32'({service_out, tx_ready, bus_out}), 32'({2'b10, b}));
                     service_in = 1'b0;
                  end else begin
                     b = rnd ? 8'($urandom_range(0, 255)) : 8'(k + 1);
                     exp_q.push_back(b);
                     bus_in = b;
                     service_in = 1'b1;
                     wait_sig(SIG_SERVICE, 1'b1, "rx_service");
                     eb = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
                     check("rx_byte", 32'({rx_valid, rx_data}), 32'({1'b1, eb}));
                     service_in = 1'b0;
                     bus_in = 8'h00;
                  end
               end
               if (v.use_stop) begin
                  wait_sig(SIG_SERVICE, 1'b0, "service_low");
                  stop = 1'b1;
                  service_in = 1'b1;
                  wait_sig(SIG_CMD, 1'b1, "stop_cmd");
                  check("stop_no_service", 32'(service_out), 32'(0));
                  service_in = 1'b0;
                  stop = 1'b0;
                  wait_sig(SIG_CMD, 1'b0, "stop_cmd_drop");
               end
               wait_sig(SIG_SERVICE, 1'b0, "service_low");
               status_handshake(v.st1);
            end
         end
      end
      wait_sig(SIG_DONE, 1'b1, "done");
      r = result; s = status; c = count;
      check("end_tags", 32'({select_out, hold_out, service_out, command_out}), 32'(0));
      @(negedge clk);
      check("busy_clear", 32'({busy, done}), 32'(0));
      operational_in = 1'b0;
      bus_in = 8'h00;
   endtask

   function automatic vec_t rand_vec();
      vec_t v;
      int pick;
      v.addr = 8'($urandom_range(0, 255));
      case ($urandom_range(0, 3))
         0:       v.cmd = 8'h01;
         1:       v.cmd = 8'h02;
         2:       v.cmd = 8'h03;
         default: v.cmd = 8'($urandom_range(4, 255));
      endcase
      pick = $urandom_range(0, 9);
      v.kind = (pick < 6) ? K_NORMAL : (pick == 6) ? K_NORESP : (pick == 7) ? K_REJECT : K_MISMATCH;
      case ($urandom_range(0, 4))
         0:       v.st0 = 8'h08;
         1:       v.st0 = 8'h30;
         2:       v.st0 = 8'($urandom_range(0, 255));
         default: v.st0 = 8'h00;
      endcase
      v.st1 = 8'($urandom_range(0, 255));
      v.nbytes = $urandom_range(0, 4);
      v.txd = $urandom_range(0, 3);
      v.use_stop = 1'b0;
      v.exp_res = 2'd0; v.exp_st = 8'h00; v.exp_cnt = 16'h0000;
      return v;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t vecs[12];
      vec_t v;
      int n_vec, fb, seen;
      logic [1:0] r, er;
      logic [7:0] s, es, last_st;
      logic [15:0] c, ec;

      vecs[0]  = mk(8'hFF, 8'h03, K_NORMAL,   8'h30, 8'h00, 0, 0, 1'b0, 2'd0, 8'h30, 16'd0);
      vecs[1]  = mk(8'h12, 8'h02, K_NORMAL,   8'h00, 8'h30, 3, 0, 1'b0, 2'd0, 8'h30, 16'd3);
      vecs[2]  = mk(8'h34, 8'h01, K_NORMAL,   8'h00, 8'h30, 2, 5, 1'b0, 2'd0, 8'h30, 16'd2);
      vecs[3]  = mk(8'h56, 8'h02, K_NORESP,   8'h00, 8'h00, 0, 0, 1'b0, 2'd2, 8'h30, 16'd0);
      vecs[4]  = mk(8'h56, 8'h02, K_NORMAL,   8'h08, 8'h00, 0, 0, 1'b0, 2'd1, 8'h08, 16'd0);
      vecs[5]  = mk(8'h77, 8'h01, K_MISMATCH, 8'h00, 8'h00, 0, 0, 1'b0, 2'd3, 8'h08, 16'd0);
      vecs[6]  = mk(8'h78, 8'h02, K_REJECT,   8'h00, 8'h00, 0, 0, 1'b0, 2'd2, 8'h08, 16'd0);
      vecs[7]  = mk(8'h9A, 8'h02, K_NORMAL,   8'h0C, 8'h00, 0, 0, 1'b0, 2'd1, 8'h0C, 16'd0);
      vecs[8]  = mk(8'h9B, 8'h01, K_NORMAL,   8'h00, 8'h0C, 0, 0, 1'b0, 2'd0, 8'h0C, 16'd0);
      vecs[9]  = mk(8'h9C, 8'h04, K_NORMAL,   8'h00, 8'h00, 0, 0, 1'b0, 2'd0, 8'h00, 16'd0);
      vecs[10] = mk(8'h21, 8'h01, K_NORMAL,   8'h00, 8'h30, 1, 0, 1'b0, 2'd0, 8'h30, 16'd1);
      n_vec = 11;
`ifdef STOP_EN
      vecs[11] = mk(8'h5C, 8'h02, K_NORMAL,   8'h00, 8'h30, 2, 0, 1'b1, 2'd0, 8'h30, 16'd2);
      n_vec = 12;
`endif

      clear_inputs();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_tags", 32'({operational_out, select_out, hold_out, address_out, command_out,
                               service_out, suppress_out, busy, done, tx_ready, rx_valid, bus_out}), 32'(0));
      check("reset_regs", 32'({result, status, count}), 32'(0));
      reset = 1'b0;
      @(negedge clk);
      check("idle_tags", 32'({operational_out, suppress_out, select_out, hold_out, address_out,
                              command_out, service_out, busy}), 32'(8'b1000_0000));

      // directed table
      last_st = 8'h00;
      for (int i = 0; i < n_vec; i++) begin
         fb = n_fail;
         run_op(vecs[i], 1'b0, r, s, c);
         check($sformatf("vec%0d_result", i), 32'(r), 32'(vecs[i].exp_res));
         check($sformatf("vec%0d_status", i), 32'(s), 32'(vecs[i].exp_st));
         check($sformatf("vec%0d_count", i), 32'(c), 32'(vecs[i].exp_cnt));
         last_st = vecs[i].exp_st;
         if (n_fail != fb) begin
            apply_reset();
            last_st = 8'h00;
         end
      end

      // randomized operations against the model
      for (int i = 0; i < 24; i++) begin
         fb = n_fail;
         v = rand_vec();
         ref_model(v, last_st, er, es, ec);
         run_op(v, 1'b1, r, s, c);
         check($sformatf("rnd%0d_result", i), 32'(r), 32'(er));
         check($sformatf("rnd%0d_status", i), 32'(s), 32'(es));
         check($sformatf("rnd%0d_count", i), 32'(c), 32'(ec));
         last_st = es;
         if (n_fail != fb) begin
            apply_reset();
            last_st = 8'h00;
         end
      end

      // reset in the middle of a read data byte
      @(negedge clk);
      address = 8'h42; command = 8'h02; start = 1'b1;
      @(negedge clk);
      start = 1'b0; operational_in = 1'b1;
      @(negedge clk);
      address_in = 1'b1; bus_in = 8'h42;
      @(negedge clk);
      address_in = 1'b0; bus_in = 8'h00;
      @(negedge clk);
      status_handshake(8'h00);
      wait_sig(SIG_SERVICE, 1'b0, "service_low");
      service_in = 1'b1; bus_in = 8'h99;
      wait_sig(SIG_SERVICE, 1'b1, "rx_service");
      #3 reset = 1'b1;
      #1;
      check("midop_reset_tags", 32'({operational_out, select_out, hold_out, address_out, command_out,
                                     service_out, suppress_out, busy, done, tx_ready, rx_valid, bus_out}), 32'(0));
      clear_inputs();
      @(negedge clk);
      reset = 1'b0;
      seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (done) seen++;
      end
      check("midop_no_done", 32'(seen), 32'(0));
      check("midop_regs_cleared", 32'({result, status, count}), 32'(0));
      check("midop_operational", 32'({operational_out, busy}), 32'(2'b10));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/channel_initiator.md
CHANNEL_INITIATOR -- requirements
Module: channel_initiator

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024: maximum cycles in SELECT before declaring no device.
REQ-002 clk  in  1  system clock; all state changes on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 start  in  1  host pulse that begins a channel program; sampled only in IDLE.
REQ-005 address / command  in  8 / 8  device address and CCW command code; latched on start.
REQ-006 busy  out  1  high from start until done.
REQ-007 done  out  1  one-cycle pulse when the sequence ends.
REQ-008 result  out  2  0=ok, 1=busy status, 2=no device, 3=address mismatch; valid with done.
REQ-009 status  out  8  last status byte received; count  out  16  data bytes transferred.
REQ-010 tx_data, tx_valid / tx_ready  in 8, in 1 / out 1  write-data stream; a byte moves when both valid and ready are high.
REQ-011 rx_data, rx_valid  out 8, out 1  read-data stream; rx_valid is a one-cycle pulse per byte.
REQ-012 stop  in  1  host request to end data transfer.
REQ-013 Channel tags: bus_out[7:0], operational_out, select_out, hold_out, address_out, command_out, service_out, suppress_out are outputs. bus_in[7:0], operational_in, select_in, address_in, status_in, service_in, request_in are inputs.

Function
REQ-014 operational_out shall be constant 1 and suppress_out constant 0; request_in is ignored.
REQ-015 IDLE: all tag outputs low except operational_out; on start go to SELECT.
REQ-016 SELECT: bus_out=address; address_out, select_out, hold_out high.
REQ-017 SELECT exits: operational_in -> ADDR_IN. select_in or timer expiry at TIMEOUT_CYCLES -> END with result=2.
REQ-018 ADDR_IN: address_out low; wait for address_in.
REQ-019 ADDR_IN check: if bus_in != address, go to END with result=3; otherwise go to CMD.
REQ-020 CMD: bus_out=command and command_out high until address_in falls; then command_out low and go to STAT.
REQ-021 STAT: on status_in, latch bus_in into status and raise service_out until status_in falls, then drop it.
REQ-022 After initial status: if status[3] (busy) -> END with result=1. If status[5:4]==2'b11 or command is not 01/02 -> END with result=0. Else count=0 and go to DATA.
REQ-023 DATA, write (command 01), on service_in: tx_ready=1. When tx_valid, tx_data drives bus_out and service_out rises, count+1, and tx_ready is held 1 for exactly that cycle. Without tx_valid, wait and do not raise service_out.
REQ-024 DATA, read (command 02), on service_in: capture bus_in to rx_data, pulse rx_valid, raise service_out, count+1.
REQ-025 After each DATA byte, service_out stays high until service_in falls; one byte per service_in assertion.
REQ-026 DATA: status_in -> ENDING, which repeats the REQ-021 handshake and then goes to END with result=0.
REQ-027 END: drop select_out/hold_out, pulse done, return to IDLE. count saturates at 16'hFFFF.

Reset
REQ-028 Reset forces IDLE, clears the timer, and drives all tag outputs, busy, done, rx_valid and tx_ready to 0.
REQ-029 Reset clears status, count, result and bus_out to 0; operational_out is 0 during reset.
REQ-030 Reset mid-sequence shall abandon the operation with no done pulse.

Configuration
REQ-031 With STOP_EN defined: in DATA, stop=1 at a service_in answers with command_out (STOP) instead of service_out. command_out is held until service_in falls, then the block goes to ENDING.
REQ-032 Without STOP_EN, the stop input is ignored and transfer ends only on CU status_in.

Verification
REQ-033 start, address=FF, command=03, CU answers CE+DE -> done, result=0, status=30, count=0.
REQ-034 start, command=02, CU sends 3 bytes then status 30 -> rx bytes 01,02,03, count=3, result=0.
REQ-035 start, command=01, tx bytes AA,BB with tx_valid delayed 5 cycles -> service_out delayed accordingly, count=2.
REQ-036 No CU response -> done after TIMEOUT_CYCLES, result=2; CU returns status 08 -> result=1.
REQ-037 STOP_EN, read with stop=1 after byte 2 -> command_out answers service_in, ending status 30, count=2.
REQ-038 Reset asserted in DATA -> all tags low next edge; no done pulse.
